// File: rtl/dcache_refill_mshr.sv
// Single-entry dcache miss holding register and line refill engine.
// Latency: accept -> bankWrite = 1 (REQ min) + memory latency + BEATS beats + 1 cycles.
// Backpressure: missReq_ready only in IDLE; memReq held until ready; memResp is never stalled.
//
// Ports:
//   clock, reset                 sole clock, synchronous active-high reset
//   io_missReq_*                 miss from the comparator (tag/index/offset/victim way)
//   io_memReq_*                  line burst read request, word address of first beat
//   io_memResp_*                 refill beats, one per valid cycle
//   io_mshr_*                    busy flag and captured tag/index back to the comparator
//   io_query_offset / io_addrHitInRefillBuffer / io_refillData
//                                combinational lookup of a word already in the buffer
//   io_bankWrite_*               one-cycle write strobe of the completed line into the victim way
//
// Build option: CRITICAL_WORD_FIRST_EN -- when defined the burst starts at the requested
// word and the fill pointer wraps from there; otherwise the burst starts at word 0.

module dcache_refill_mshr #(
  parameter  int TAG_W   = 28,
  parameter  int INDEX_W = 1,
  parameter  int DATA_W  = 32,
  parameter  int BEATS   = 2,
  parameter  int WAYS    = 2,
  localparam int OFF_W   = $clog2(BEATS),
  localparam int WAY_W   = $clog2(WAYS)
) (
  input  logic                         clock,
  input  logic                         reset,

  input  logic                         io_missReq_valid,
  output logic                         io_missReq_ready,
  input  logic [TAG_W-1:0]             io_missReq_tag,
  input  logic [INDEX_W-1:0]           io_missReq_index,
  input  logic [OFF_W-1:0]             io_missReq_offset,
  input  logic [WAY_W-1:0]             io_missReq_way,

  output logic                         io_memReq_valid,
  input  logic                         io_memReq_ready,
  output logic [TAG_W+INDEX_W+OFF_W-1:0] io_memReq_addr,

  input  logic                         io_memResp_valid,
  input  logic [DATA_W-1:0]            io_memResp_data,

  output logic                         io_mshr_valid,
  output logic [TAG_W-1:0]             io_mshr_tag,
  output logic [INDEX_W-1:0]           io_mshr_index,

  input  logic [OFF_W-1:0]             io_query_offset,
  output logic                         io_addrHitInRefillBuffer,
  output logic [DATA_W-1:0]            io_refillData,

  output logic                         io_bankWrite_valid,
  output logic [WAY_W-1:0]             io_bankWrite_way,
  output logic [INDEX_W-1:0]           io_bankWrite_index,
  output logic [TAG_W-1:0]             io_bankWrite_tag,
  output logic [BEATS*DATA_W-1:0]      io_bankWrite_data
);

  localparam int                CNT_W    = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_RECV  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic [OFF_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BEATS-1:0]    filled_q, filled_d;
  logic [DATA_W-1:0]   line_q [BEATS];
  logic [DATA_W-1:0]   line_d [BEATS];

  // Word the fill pointer starts from; it also forms the offset field of the
  // burst address, because ptr_q is untouched until the first beat arrives.
  logic [OFF_W-1:0]    first_ptr;

`ifdef CRITICAL_WORD_FIRST_EN
  assign first_ptr = io_missReq_offset;
`else
  assign first_ptr = '0;
  // The requested offset only matters when the burst is reordered.
  logic unused_offset;
  assign unused_offset = ^io_missReq_offset;
`endif

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    index_d  = index_q;
    way_d    = way_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    filled_d = filled_q;
    line_d   = line_q;

    case (state_q)
      S_IDLE: begin
        if (io_missReq_valid) begin
          tag_d    = io_missReq_tag;
          index_d  = io_missReq_index;
          way_d    = io_missReq_way;
          ptr_d    = first_ptr;
          cnt_d    = '0;
          filled_d = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        // A beat in the handshake cycle is not legal and is dropped.
        if (io_memReq_ready) state_d = S_RECV;
      end
      S_RECV: begin
        if (io_memResp_valid) begin
          line_d[ptr_q]   = io_memResp_data;
          filled_d[ptr_q] = 1'b1;
          ptr_d           = ptr_q + 1'b1;  // wraps mod BEATS (power of two)
          cnt_d           = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tag_q    <= '0;
      index_q  <= '0;
      way_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      filled_q <= '0;
      for (int i = 0; i < BEATS; i++) line_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      index_q  <= index_d;
      way_q    <= way_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      filled_q <= filled_d;
      for (int i = 0; i < BEATS; i++) line_q[i] <= line_d[i];
    end
  end

  // Handshake and strobe outputs decode straight from the state flop.
  assign io_missReq_ready   = (state_q == S_IDLE);
  assign io_memReq_valid    = (state_q == S_REQ);
  assign io_memReq_addr     = {tag_q, index_q, ptr_q};
  assign io_mshr_valid      = (state_q != S_IDLE);
  assign io_mshr_tag        = tag_q;
  assign io_mshr_index      = index_q;
  assign io_bankWrite_valid = (state_q == S_WRITE);
  assign io_bankWrite_way   = way_q;
  assign io_bankWrite_index = index_q;
  assign io_bankWrite_tag   = tag_q;

  // Only the word offset is looked up here; the comparator matches tag/index.
  assign io_addrHitInRefillBuffer = io_mshr_valid & filled_q[io_query_offset];
  assign io_refillData            = line_q[io_query_offset];

  // The buffer is indexed by word, so the line is always in natural order.
  always_comb begin
    io_bankWrite_data = '0;
    for (int i = 0; i < BEATS; i++) begin
      io_bankWrite_data[i*DATA_W +: DATA_W] = line_q[i];
    end
  end

endmodule

// File: tb/tb_dcache_refill_mshr.sv
module tb_dcache_refill_mshr;

  localparam int TAG_W   = 28;
  localparam int INDEX_W = 1;
  localparam int DATA_W  = 32;
  localparam int BEATS   = 2;
  localparam int WAYS    = 2;
  localparam int OFF_W   = $clog2(BEATS);
  localparam int WAY_W   = $clog2(WAYS);
  localparam int ADDR_W  = TAG_W + INDEX_W + OFF_W;
  localparam int NRAND   = 40;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     io_missReq_valid;
  logic                     io_missReq_ready;
  logic [TAG_W-1:0]         io_missReq_tag;
  logic [INDEX_W-1:0]       io_missReq_index;
  logic [OFF_W-1:0]         io_missReq_offset;
  logic [WAY_W-1:0]         io_missReq_way;
  logic                     io_memReq_valid;
  logic                     io_memReq_ready;
  logic [ADDR_W-1:0]        io_memReq_addr;
  logic                     io_memResp_valid;
  logic [DATA_W-1:0]        io_memResp_data;
  logic                     io_mshr_valid;
  logic [TAG_W-1:0]         io_mshr_tag;
  logic [INDEX_W-1:0]       io_mshr_index;
  logic [OFF_W-1:0]         io_query_offset;
  logic                     io_addrHitInRefillBuffer;
  logic [DATA_W-1:0]        io_refillData;
  logic                     io_bankWrite_valid;
  logic [WAY_W-1:0]         io_bankWrite_way;
  logic [INDEX_W-1:0]       io_bankWrite_index;
  logic [TAG_W-1:0]         io_bankWrite_tag;
  logic [BEATS*DATA_W-1:0]  io_bankWrite_data;

  dcache_refill_mshr #(
    .TAG_W(TAG_W), .INDEX_W(INDEX_W), .DATA_W(DATA_W), .BEATS(BEATS), .WAYS(WAYS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io_missReq_valid(io_missReq_valid),
    .io_missReq_ready(io_missReq_ready),
    .io_missReq_tag(io_missReq_tag),
    .io_missReq_index(io_missReq_index),
    .io_missReq_offset(io_missReq_offset),
    .io_missReq_way(io_missReq_way),
    .io_memReq_valid(io_memReq_valid),
    .io_memReq_ready(io_memReq_ready),
    .io_memReq_addr(io_memReq_addr),
    .io_memResp_valid(io_memResp_valid),
    .io_memResp_data(io_memResp_data),
    .io_mshr_valid(io_mshr_valid),
    .io_mshr_tag(io_mshr_tag),
    .io_mshr_index(io_mshr_index),
    .io_query_offset(io_query_offset),
    .io_addrHitInRefillBuffer(io_addrHitInRefillBuffer),
    .io_refillData(io_refillData),
    .io_bankWrite_valid(io_bankWrite_valid),
    .io_bankWrite_way(io_bankWrite_way),
    .io_bankWrite_index(io_bankWrite_index),
    .io_bankWrite_tag(io_bankWrite_tag),
    .io_bankWrite_data(io_bankWrite_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] idx;
    logic [OFF_W-1:0]   off;
    logic [WAY_W-1:0]   way;
    logic [DATA_W-1:0]  base;      // memory word w of this line holds base + w
    int                 req_wait;  // cycles memReq_ready stays low
    int                 gap;       // idle cycles between beats; <0 means random
    bit                 junk;      // stray beats in cycles where they must be ignored
  } miss_t;

  typedef struct packed {
    logic [WAY_W-1:0]        way;
    logic [INDEX_W-1:0]      idx;
    logic [TAG_W-1:0]        tag;
    logic [BEATS*DATA_W-1:0] data;
  } bw_t;

  bw_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: expected line is word w = base + w, whatever order memory returns it in.
  function automatic bw_t expected_write(input miss_t m);
    bw_t e;
    e.way = m.way;
    e.idx = m.idx;
    e.tag = m.tag;
    e.data = '0;
    for (int w = 0; w < BEATS; w++) e.data[w*DATA_W +: DATA_W] = m.base + DATA_W'(w);
    return e;
  endfunction

  function automatic int start_word(input miss_t m);
`ifdef CRITICAL_WORD_FIRST_EN
    return int'(m.off);
`else
    return 0;
`endif
  endfunction

  // Sweeps every query offset; hit must equal "entry busy and word already received".
  task automatic check_buffer(input miss_t m, input logic [BEATS-1:0] have, input bit busy);
    for (int q = 0; q < BEATS; q++) begin
      io_query_offset = OFF_W'(q);
      #1;
      chk($sformatf("hit[%0d]", q), io_addrHitInRefillBuffer, busy & have[q]);
      if (busy && have[q]) chk($sformatf("refillData[%0d]", q), io_refillData, m.base + DATA_W'(q));
    end
  endtask

  task automatic drive_miss(input miss_t m);
    io_missReq_valid  = 1'b1;
    io_missReq_tag    = m.tag;
    io_missReq_index  = m.idx;
    io_missReq_offset = m.off;
    io_missReq_way    = m.way;
  endtask

  task automatic run_miss(input miss_t m, input bit have_next, input miss_t nx, input bit expect_immediate);
    logic [BEATS-1:0]  have;
    logic [ADDR_W-1:0] exp_addr;
    int                waits;
    int                g;
    int                w;
    have = '0;
    exp_addr = {m.tag, m.idx, OFF_W'(start_word(m))};

    @(negedge clock);
    drive_miss(m);
    io_memResp_valid = 1'b0;
    io_memReq_ready  = 1'b0;
    #1;
    waits = 0;
    while (!io_missReq_ready && waits < 40) begin
      @(negedge clock);
      #1;
      waits++;
    end
    if (expect_immediate) chk("b2b_accept_wait", waits, 0);
    if (!io_missReq_ready) begin
      chk("accept_timeout", 0, 1);
      io_missReq_valid = 1'b0;
      return;
    end
    exp_q.push_back(expected_write(m));

    // REQ: address held stable through every backpressure cycle and the handshake.
    @(negedge clock);
    if (have_next) drive_miss(nx);
    else io_missReq_valid = 1'b0;
    for (int c = 0; c <= m.req_wait; c++) begin
      if (c > 0) @(negedge clock);
      io_memReq_ready  = (c == m.req_wait);
      io_memResp_valid = m.junk && (c == 0 || c == m.req_wait);
      io_memResp_data  = ~m.base;
      check_buffer(m, have, 1'b1);
      chk("memReq_valid", io_memReq_valid, 1);
      chk("memReq_addr", io_memReq_addr, exp_addr);
      chk("missReq_ready_req", io_missReq_ready, 0);
      chk("mshr_tag", io_mshr_tag, m.tag);
      chk("mshr_index", io_mshr_index, m.idx);
    end

    // RECV: beats in wrapped order starting at the first word.
    for (int k = 0; k < BEATS; k++) begin
      g = (m.gap < 0) ? int'($urandom_range(0, 2)) : ((k == 0) ? 0 : m.gap);
      for (int i = 0; i < g; i++) begin
        @(negedge clock);
        io_memReq_ready  = 1'b0;
        io_memResp_valid = 1'b0;
        check_buffer(m, have, 1'b1);
        chk("missReq_ready_recv", io_missReq_ready, 0);
      end
      w = (start_word(m) + k) % BEATS;
      @(negedge clock);
      io_memReq_ready  = 1'b0;
      io_memResp_valid = 1'b1;
      io_memResp_data  = m.base + DATA_W'(w);
      check_buffer(m, have, 1'b1);   // this beat not yet visible
      chk("memReq_valid_recv", io_memReq_valid, 0);
      have[w] = 1'b1;
    end

    // WRITE: full line visible, stray beat ignored.
    @(negedge clock);
    io_memResp_valid = m.junk;
    io_memResp_data  = ~m.base;
    check_buffer(m, have, 1'b1);
    chk("missReq_ready_write", io_missReq_ready, 0);
  endtask

  function automatic miss_t rand_miss();
    miss_t m;
    m.tag      = TAG_W'($urandom);
    m.idx      = INDEX_W'($urandom);
    m.off      = OFF_W'($urandom);
    m.way      = WAY_W'($urandom);
    m.base     = $urandom & 32'hFFFF_FFF0;
    m.req_wait = int'($urandom_range(0, 3));
    m.gap      = -1;
    m.junk     = 1'(($urandom & 1));
    return m;
  endfunction

  // Scoreboard monitor: compares each bankWrite strobe against the oldest expectation.
  logic prev_bw = 1'b0;
  always @(posedge clock) begin
    bw_t e;
    #1;
    if (io_bankWrite_valid) begin
      chk("bw_adjacent", prev_bw, 0);
      if (exp_q.size() == 0) begin
        chk("bw_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("bw_way", io_bankWrite_way, e.way);
        chk("bw_index", io_bankWrite_index, e.idx);
        chk("bw_tag", io_bankWrite_tag, e.tag);
        chk("bw_data", io_bankWrite_data, e.data);
      end
    end
    prev_bw = io_bankWrite_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    miss_t basic, m, a, b, none;
    miss_t list[NRAND + 1];
    bit    chain[NRAND + 1];
    bit    prev_chain;

    reset = 1'b1;
    io_missReq_valid = 1'b0;
    io_missReq_tag = '0;
    io_missReq_index = '0;
    io_missReq_offset = '0;
    io_missReq_way = '0;
    io_memReq_ready = 1'b0;
    io_memResp_valid = 1'b0;
    io_memResp_data = '0;
    io_query_offset = '0;

    basic.tag = 28'h1234567; basic.idx = 1'b1; basic.off = 1'b1; basic.way = 1'b1;
    basic.base = 32'hA0; basic.req_wait = 0; basic.gap = 0; basic.junk = 1'b0;
    none = basic;

    repeat (3) @(negedge clock);
    #1;
    chk("rst_missReq_ready", io_missReq_ready, 1);
    chk("rst_memReq_valid", io_memReq_valid, 0);
    chk("rst_mshr_valid", io_mshr_valid, 0);
    chk("rst_bankWrite_valid", io_bankWrite_valid, 0);
    chk("rst_mshr_tag", io_mshr_tag, 0);
    @(negedge clock);
    reset = 1'b0;

    run_miss(basic, 1'b0, none, 1'b0);

    m = basic; m.req_wait = 5; m.base = 32'hB0;
    run_miss(m, 1'b0, none, 1'b0);

    m = basic; m.gap = 2; m.base = 32'hC0; m.off = 1'b0;
    run_miss(m, 1'b0, none, 1'b0);

    // Reset in the middle of a refill abandons the entry.
    @(negedge clock);
    drive_miss(basic);
    #1;
    chk("mid_accept_ready", io_missReq_ready, 1);
    @(negedge clock);
    io_missReq_valid = 1'b0;
    io_memReq_ready  = 1'b1;
    @(negedge clock);
    io_memReq_ready  = 1'b0;
    io_memResp_valid = 1'b1;
    io_memResp_data  = 32'h55;
    @(negedge clock);
    io_memResp_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_buffer(basic, '1, 1'b0);
    chk("mid_rst_mshr_valid", io_mshr_valid, 0);
    chk("mid_rst_missReq_ready", io_missReq_ready, 1);
    chk("mid_rst_memReq_valid", io_memReq_valid, 0);
    @(negedge clock);
    io_memResp_valid = 1'b1;
    io_memResp_data  = 32'hDEAD;
    #1;
    chk("stray_idle_mshr_valid", io_mshr_valid, 0);
    @(negedge clock);
    io_memResp_valid = 1'b0;
    #1;
    chk("stray_idle_ready", io_missReq_ready, 1);
    m = basic; m.base = 32'hD0;
    run_miss(m, 1'b0, none, 1'b0);

    // Back-to-back: second miss held valid throughout the first refill.
    a = basic; a.base = 32'hE0; a.gap = 1;
    b = basic; b.base = 32'hF0; b.tag = 28'h7654321; b.idx = 1'b0; b.way = 1'b0; b.off = 1'b0;
    run_miss(a, 1'b1, b, 1'b0);
    run_miss(b, 1'b0, none, 1'b1);

    for (int i = 0; i <= NRAND; i++) begin
      list[i]  = rand_miss();
      chain[i] = (i < NRAND) ? 1'(($urandom & 1)) : 1'b0;
    end
    prev_chain = 1'b0;
    for (int i = 0; i < NRAND; i++) begin
      run_miss(list[i], chain[i], list[i + 1], prev_chain);
      prev_chain = chain[i];
    end
    if (prev_chain) run_miss(list[NRAND], 1'b0, none, 1'b1);

    @(negedge clock);
    io_missReq_valid = 1'b0;
    io_memResp_valid = 1'b0;
    repeat (4) @(negedge clock);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
